demux1to32_collect: RTL and testbench
=====================================

# demux1to32_collect

Receive-side counterpart of the 32-to-1 bit multiplexer. It accepts one serial bit per transfer, tagged with its 5-bit slot select, and demultiplexes it into slot S of a 32-bit word. When all 32 slots have been written, it presents the reassembled word on a ready/valid output. It sits at the far end of a link where a 32-to-1 mux, stepped by a select counter, serialises a word onto one wire.

## Interface
- `N`, 32: word width and slot count; fixed at 32 in this revision.
- `SW`, 5: select width; log2(N).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  S/D carry a bit this cycle.
- `in_ready`  out  1  block can accept a bit; low only in HOLD.
- `S`  in  SW  slot select for D.
- `D`  in  1  serial data bit (the mux Y).
- `out_valid`  out  1  Y holds a complete word.
- `out_ready`  in  1  consumer takes Y.
- `Y`  out  N  reassembled word.
- `err`  out  1  one-cycle pulse on a protocol violation.
- `busy`  out  1  at least one slot written, word not yet delivered.

## Operation
- State machine: IDLE, FILL, HOLD.
- Accept condition: `in_valid && in_ready`. On accept:
  - `word[S] <= D`.
  - `mask[S] <= 1`.
  - IDLE moves to FILL.
- Completion: when the accept makes mask all ones (including the current write), the state moves to HOLD, `out_valid <= 1`, and `Y <= word` with the current bit merged in.
- HOLD:
  - `in_ready = 0`; `in_valid` is ignored, and no err is raised for it.
  - Y is stable.
  - When `out_valid && out_ready`: mask clears, word clears, state goes to IDLE, and `out_valid` goes low on the next edge.
- Duplicate slot: an accept in FILL to a slot whose mask bit is already set overwrites the bit and pulses err. The mask is unchanged.
- `busy = (state==FILL) || (state==HOLD)`.
- `Y` changes only on the completion edge and on reset. Word and mask clear on handoff.

## Timing
- Reset (asynchronous, while `rst_n=0`):
  - state = IDLE.
  - mask = 0, word = 0, Y = 0.
  - `out_valid=0`, `err=0`, `busy=0`, `in_ready=1`.
- Latency: `out_valid` rises on the same edge that accepts the 32nd distinct slot. Minimum is 32 cycles from the first accept.
- The consumer may hold `out_ready` high permanently. The word is then delivered one cycle after completion, and the block accepts new bits from the cycle after that.
- Back-to-back words: the first accept for the next word can occur the cycle after the handoff edge.
- `err` is registered. It is high for exactly the cycle after the offending accept.
- Reset asserted mid-FILL or mid-HOLD discards the partial or pending word with no output.

## Configuration
- `DEMUX_ORDER_CHECK_EN` defined:
  - Adds a 5-bit expected-slot counter `exp`, reset to 0.
  - An accept with `S==exp` is stored and increments `exp`, which wraps 31→0 on completion.
  - An accept with `S!=exp` is dropped: no store, no mask change, err pulses.
  - Duplicate detection is subsumed by the order check.
- `DEMUX_ORDER_CHECK_EN` undefined: any slot order is accepted, and completion is purely mask-based as described above.

## Test plan
- In-order stream: drive `D = bit s of 32'd640` for `s=0..31`, one per cycle, with `out_ready=1`. Required: `out_valid` high for exactly 1 cycle with `Y=32'h00000280`, and err never pulses.
- Reverse order, macro undefined: the same word with `s=31..0`. Required: `Y=32'h00000280`. With the macro defined, the same stimulus instead gives err on 31 of the accepts, and out_valid never rises.
- Backpressure: complete `Y=32'hDEADBEEF` with `out_ready=0` for 10 cycles while `in_valid=1`. Required: `in_ready=0`, Y is stable, and out_valid is held. After `out_ready=1`, one handoff, then IDLE.
- Duplicate: write slot 3 with D=1, then slot 3 with D=0, then the remaining 31 slots with D=1. Required: one err pulse, and `Y=32'hFFFFFFF7`.
- Reset mid-word: 16 slots written, then `rst_n` pulsed low. Required: Y=0, out_valid=0, busy=0. A following full word is delivered correctly with no stale bits.

Source files
------------

// File: rtl/demux1to32_collect.sv
// -----------------------------------------------------------------------------
// demux1to32_collect
//
// Receive side of a 32-to-1 serialising mux. Each accepted transfer carries
// one data bit D tagged with its slot select S; the bit is written into slot
// S of a 32-bit word. When every slot has been written, the reassembled word
// is presented on Y with a ready/valid handshake.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   S/D carry a bit this cycle
//   in_ready   out  block can take a bit (low only while holding a word)
//   S          in   slot select for D
//   D          in   serial data bit
//   out_valid  out  Y holds a complete word
//   out_ready  in   consumer takes Y
//   Y          out  reassembled word
//   err        out  one-cycle pulse after a protocol violation
//   busy       out  at least one slot written, word not yet delivered
//
// Build option:
//   DEMUX_ORDER_CHECK_EN  when defined, slots must arrive in order 0..31;
//                         an out-of-order bit is dropped and flagged on err.
//                         When undefined, any order is accepted and a
//                         rewrite of an already-filled slot is flagged.
// -----------------------------------------------------------------------------
module demux1to32_collect #(
  parameter int N  = 32,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] S,
  input  logic          D,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  Y,
  output logic          err,
  output logic          busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] word_q, word_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] y_q, y_d;
  logic         out_valid_q, out_valid_d;
  logic         err_q, err_d;
  logic         store_s;
  logic         bad_s;

`ifdef DEMUX_ORDER_CHECK_EN
  logic [SW-1:0] exp_q, exp_d;
`endif

  // Classify the incoming bit: store_s means it is written, bad_s raises err.
  always_comb begin
    store_s = 1'b0;
    bad_s   = 1'b0;
    if (in_valid && (state_q != ST_HOLD)) begin
`ifdef DEMUX_ORDER_CHECK_EN
      if (S == exp_q) begin
        store_s = 1'b1;
        bad_s   = 1'b0;
      end else begin
        store_s = 1'b0;
        bad_s   = 1'b1;
      end
`else
      store_s = 1'b1;
      // A rewrite of a filled slot is only possible once filling has begun.
      bad_s   = (state_q == ST_FILL) && mask_q[S];
`endif
    end else begin
      store_s = 1'b0;
      bad_s   = 1'b0;
    end
  end

  // Next-state logic for the collect / hold / handoff sequence.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    mask_d      = mask_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    err_d       = bad_s;
`ifdef DEMUX_ORDER_CHECK_EN
    exp_d       = exp_q;
`endif
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (store_s) begin
          word_d[S] = D;
          mask_d[S] = 1'b1;
`ifdef DEMUX_ORDER_CHECK_EN
          // Wraps 31 -> 0 on the completing accept.
          exp_d     = exp_q + 5'd1;
`endif
          if (&mask_d) begin
            // Completion: Y takes the word with the current bit merged in.
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            y_d         = word_d;
          end else begin
            state_d     = ST_FILL;
            out_valid_d = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d     = ST_IDLE;
          word_d      = '0;
          mask_d      = '0;
          out_valid_d = 1'b0;
        end else begin
          state_d     = ST_HOLD;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        word_d      = '0;
        mask_d      = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      mask_q      <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      mask_q      <= mask_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

`ifdef DEMUX_ORDER_CHECK_EN
  // Expected-slot counter for the in-order check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= 5'd0;
    end else begin
      exp_q <= exp_d;
    end
  end
`endif

  assign in_ready  = (state_q != ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign Y         = y_q;
  assign err       = err_q;

endmodule

// File: tb/tb_demux1to32_collect.sv
module tb_demux1to32_collect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  S;
  logic        D;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Y;
  logic        err;
  logic        busy;

  int n_vec  = 0;
  int n_fail = 0;

  // Observation counters written by the compare process.
  int          ov_cycles = 0;
  int          err_cnt   = 0;
  logic [31:0] y_cap     = 32'd0;

  // Behavioural model: set of received slots, their bits, a holding flag.
  logic [31:0] m_word = 32'd0;
  logic [31:0] m_have = 32'd0;
  logic        m_hold = 1'b0;
  logic [31:0] m_y    = 32'd0;
  logic        m_err  = 1'b0;

  demux1to32_collect dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .D(D), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: a word is complete once all 32 slots have been seen.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_word = 32'd0; m_have = 32'd0; m_hold = 1'b0; m_y = 32'd0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_hold) begin
        if (out_ready) begin
          m_hold = 1'b0; m_word = 32'd0; m_have = 32'd0;
        end
      end else if (in_valid) begin
        if (m_have[S]) m_err = 1'b1;
        m_word[S] = D;
        m_have[S] = 1'b1;
        if ($countones(m_have) == 32) begin
          m_hold = 1'b1;
          m_y    = m_word;
        end
      end
    end
  end

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_hold});
    chk("in_ready",  {31'd0, in_ready},  {31'd0, !m_hold});
    chk("busy",      {31'd0, busy},      {31'd0, (m_hold || (m_have != 32'd0))});
    chk("err",       {31'd0, err},       {31'd0, m_err});
    chk("Y",         Y,                  m_y);
    if (out_valid) begin
      ov_cycles++;
      y_cap = Y;
    end
    if (err) err_cnt++;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int s, input logic d);
    cyc();
    in_valid = 1'b1;
    S        = s[4:0];
    D        = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      in_valid = 1'b0;
    end
  endtask

  task automatic clear_obs();
    ov_cycles = 0;
    err_cnt   = 0;
    y_cap     = 32'd0;
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b0; in_valid = 1'b0; S = 5'd0; D = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();
    chk("reset Y", Y, 32'd0);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // In-order stream of 640.
    clear_obs();
    w = 32'd640;
    for (int s = 0; s < 32; s++) send(s, w[s]);
    idle(4);
    chk("inorder ov_cycles", ov_cycles, 32'd1);
    chk("inorder Y", y_cap, 32'h0000_0280);
    chk("inorder model Y", m_y, 32'h0000_0280);
    chk("inorder err_cnt", err_cnt, 32'd0);

    // Reverse order, same word.
    clear_obs();
    for (int s = 31; s >= 0; s--) send(s, w[s]);
    idle(4);
    chk("reverse ov_cycles", ov_cycles, 32'd1);
    chk("reverse Y", y_cap, 32'h0000_0280);
    chk("reverse err_cnt", err_cnt, 32'd0);

    // Backpressure with DEADBEEF while in_valid keeps asserting.
    clear_obs();
    out_ready = 1'b0;
    w = 32'hDEAD_BEEF;
    for (int s = 0; s < 32; s++) send(s, w[s]);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp Y", Y, 32'hDEAD_BEEF);
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1; S = i[4:0]; D = ~w[i];
    end
    cyc();
    in_valid = 1'b0; out_ready = 1'b1;
    idle(2);
    chk("bp ov_cycles", ov_cycles, 32'd11);
    chk("bp after out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp after busy", {31'd0, busy}, 32'd0);
    chk("bp after Y", Y, 32'hDEAD_BEEF);
    chk("bp err_cnt", err_cnt, 32'd0);

    // Duplicate slot 3.
    clear_obs();
    send(3, 1'b1);
    send(3, 1'b0);
    for (int s = 0; s < 32; s++) if (s != 3) send(s, 1'b1);
    idle(4);
    chk("dup err_cnt", err_cnt, 32'd1);
    chk("dup Y", y_cap, 32'hFFFF_FFF7);
    chk("dup model Y", m_y, 32'hFFFF_FFF7);
    chk("dup ov_cycles", ov_cycles, 32'd1);

    // Reset mid-word, then a clean word.
    clear_obs();
    for (int s = 0; s < 16; s++) send(s, 1'b1);
    cyc();
    in_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    chk("midrst Y", Y, 32'd0);
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(1);
    w = 32'h1234_5678;
    for (int s = 0; s < 32; s++) send(s, w[s]);
    idle(4);
    chk("midrst ov_cycles", ov_cycles, 32'd1);
    chk("midrst Y word", y_cap, 32'h1234_5678);
    chk("midrst err_cnt", err_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
